// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the in-place radix-2 FFT address sequencer.
package fft_pkg;
  localparam int LOG2N   = 5;
  localparam int N       = 1 << LOG2N;
  localparam int ADDR_W  = LOG2N;
  localparam int TW_W    = LOG2N - 1;
  localparam int STAGE_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } fft_state_e;
endpackage

// File: rtl/fft_bfly_addr.sv
// Maps (stage, butterfly index) to the two in-place leg addresses and the twiddle index.
module fft_bfly_addr #(
  parameter int LOG2N = fft_pkg::LOG2N
) (
  input  logic [2:0]       stage,
  input  logic [LOG2N-2:0] k,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] twiddle_idx
);
  localparam int              TWW    = LOG2N - 1;
  localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);
  localparam logic [2:0]       SH_MAX = 3'(LOG2N - 1);

  logic [LOG2N-1:0] kx, span, pos, grp, a;

  always_comb begin
    kx     = {1'b0, k};
    span   = ONE << stage;
    pos    = kx & (span - ONE);
    grp    = kx >> stage;
    // group base skips the other half of each group, pos walks within it
    a      = (grp << ({1'b0, stage} + 4'd1)) | pos;
    addr_a = a;
    addr_b = a + span;
    twiddle_idx = TWW'(pos << (SH_MAX - stage));
  end
endmodule

// File: rtl/fft_addr_ctrl.sv
// Stage/butterfly sequencer: READ, BF_LAT CALC cycles, WRITE per butterfly, then DONE.
module fft_addr_ctrl #(
  parameter int LOG2N  = fft_pkg::LOG2N,
  parameter int BF_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] ram_addr_a,
  output logic [LOG2N-1:0] ram_addr_b,
  output logic             ram_wr_a,
  output logic             ram_wr_b,
  output logic             bf_in_valid,
  output logic [LOG2N-2:0] twiddle_idx,
  output logic [2:0]       stage
);
  import fft_pkg::*;

  localparam int             CW         = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(BF_LAT - 1);
  localparam logic [2:0]     STAGE_LAST = 3'(LOG2N - 1);

  fft_state_e       state, state_nxt;
  logic [2:0]       stage_q, stage_nxt;
  logic [LOG2N-2:0] k_q, k_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;

  logic [LOG2N-1:0] addr_a_c, addr_b_c;
  logic [LOG2N-2:0] tw_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      stage_q <= '0;
      k_q     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      stage_q <= stage_nxt;
      k_q     <= k_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stage_nxt = stage_q;
    k_nxt     = k_q;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (start) begin
        state_nxt = READ;
        stage_nxt = '0;
        k_nxt     = '0;
      end
      READ: begin
        state_nxt = CALC;
        cnt_nxt   = '0;
      end
      CALC: begin
        if (cnt == CNT_LAST) state_nxt = WRITE;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      WRITE: begin
        if (k_q != '1) begin
          k_nxt     = k_q + 1'b1;
          state_nxt = READ;
        end else if (stage_q != STAGE_LAST) begin
          stage_nxt = stage_q + 3'd1;
          k_nxt     = '0;
          state_nxt = READ;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Addresses come from the next (stage, k) so they land on the edge entering READ.
  fft_bfly_addr #(.LOG2N(LOG2N)) u_bfly_addr (
    .stage       (stage_nxt),
    .k           (k_nxt),
    .addr_a      (addr_a_c),
    .addr_b      (addr_b_c),
    .twiddle_idx (tw_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_wr_a    <= 1'b0;
      ram_wr_b    <= 1'b0;
      bf_in_valid <= 1'b0;
      ram_addr_a  <= '0;
      ram_addr_b  <= '0;
      twiddle_idx <= '0;
      stage       <= '0;
    end else begin
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
      ram_wr_a    <= (state_nxt == WRITE);
      ram_wr_b    <= (state_nxt == WRITE);
      // RAM read data is registered at the READ edge, so operands appear in the first CALC cycle
      bf_in_valid <= (state == READ);
      if (state_nxt == READ) begin
        ram_addr_a  <= addr_a_c;
        ram_addr_b  <= addr_b_c;
        twiddle_idx <= tw_c;
        stage       <= stage_nxt;
      end
    end
  end
endmodule

// File: tb/tb_fft_addr_ctrl.sv
// Randomized bench for fft_addr_ctrl against a cycle-timeline reference model and RAM/butterfly scoreboard.
module tb_fft_addr_ctrl;
  localparam int  LOG2N  = 5;
  localparam int  BF_LAT = 2;
  localparam int  P      = 2 + BF_LAT;
  localparam int  HALF   = 1 << (LOG2N - 1);
  localparam int  NPT    = 1 << LOG2N;
  localparam int  TOTAL  = LOG2N * HALF * P;
  localparam real PI     = 3.14159265358979;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             busy, done, ram_wr_a, ram_wr_b, bf_in_valid;
  logic [LOG2N-1:0] ram_addr_a, ram_addr_b;
  logic [LOG2N-2:0] twiddle_idx;
  logic [2:0]       stage;

  fft_addr_ctrl #(.LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .ram_addr_a  (ram_addr_a),
    .ram_addr_b  (ram_addr_b),
    .ram_wr_a    (ram_wr_a),
    .ram_wr_b    (ram_wr_b),
    .bf_in_valid (bf_in_valid),
    .twiddle_idx (twiddle_idx),
    .stage       (stage)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: run position t (0 = idle, 1..TOTAL butterflies, TOTAL+1 = done cycle)
  function automatic int nxt_t(int t, logic st);
    if (t == 0)       return (st === 1'b1) ? 1 : 0;
    if (t == TOTAL+1) return 0;
    return t + 1;
  endfunction

  function automatic int ref_a(int n);
    int s, k, span;
    s = n / HALF; k = n % HALF; span = 1 << s;
    return (k / span) * 2 * span + (k % span);
  endfunction

  function automatic int ref_span(int n);
    return 1 << (n / HALF);
  endfunction

  function automatic int ref_tw(int n);
    int s, k;
    s = n / HALF; k = n % HALF;
    return (k % (1 << s)) * (HALF >> s);
  endfunction

  function automatic logic in_phase(int t, int ph);
    return (t >= 1 && t <= TOTAL && ((t - 1) % P) == ph);
  endfunction

  int m_t, m_nt, m_a, m_b, m_tw, m_s;
  always_comb m_nt = nxt_t(m_t, start);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_a <= 0; m_b <= 0; m_tw <= 0; m_s <= 0;
    end else begin
      m_t <= m_nt;
      if (in_phase(m_nt, 0)) begin
        m_a  <= ref_a((m_nt - 1) / P);
        m_b  <= ref_a((m_nt - 1) / P) + ref_span((m_nt - 1) / P);
        m_tw <= ref_tw((m_nt - 1) / P);
        m_s  <= ((m_nt - 1) / P) / HALF;
      end
    end
  end

  // RAM model and golden complex butterfly driven by the DUT's own addresses and strobes
  real re [NPT];
  real im [NPT];
  int  wcnt [NPT];
  int  nwr;
  real h_ar, h_ai, h_tr, h_ti;
  bit  mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy",   busy,        m_t != 0);
      chk("done",   done,        m_t == TOTAL + 1);
      chk("wr_a",   ram_wr_a,    in_phase(m_t, P - 1));
      chk("wr_b",   ram_wr_b,    in_phase(m_t, P - 1));
      chk("valid",  bf_in_valid, in_phase(m_t, 1));
      chk("addr_a", ram_addr_a,  m_a);
      chk("addr_b", ram_addr_b,  m_b);
      chk("twid",   twiddle_idx, m_tw);
      chk("stage",  stage,       m_s);
      if (bf_in_valid) begin
        h_ar <= re[ram_addr_a];
        h_ai <= im[ram_addr_a];
        h_tr <= re[ram_addr_b] * $cos(2.0*PI*real'(twiddle_idx)/NPT)
              + im[ram_addr_b] * $sin(2.0*PI*real'(twiddle_idx)/NPT);
        h_ti <= im[ram_addr_b] * $cos(2.0*PI*real'(twiddle_idx)/NPT)
              - re[ram_addr_b] * $sin(2.0*PI*real'(twiddle_idx)/NPT);
      end
      if (ram_wr_a) begin
        re[ram_addr_a]   <= h_ar + h_tr;
        im[ram_addr_a]   <= h_ai + h_ti;
        re[ram_addr_b]   <= h_ar - h_tr;
        im[ram_addr_b]   <= h_ai - h_ti;
        wcnt[ram_addr_a] <= wcnt[ram_addr_a] + 1;
        wcnt[ram_addr_b] <= wcnt[ram_addr_b] + 1;
        nwr              <= nwr + 1;
      end
    end
  end

  task automatic wait_done(input int lim);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
  endtask

  initial begin
    int done_at, last_wr, ndone;

    repeat (3) @(negedge clk);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_wr",    {ram_wr_a, ram_wr_b}, 0);
    chk("rst_valid", bf_in_valid, 0);
    chk("rst_addr",  {ram_addr_a, ram_addr_b}, 0);
    chk("rst_twid",  twiddle_idx, 0);
    chk("rst_stage", stage, 0);
    rst_n  = 1'b1;
    for (int i = 0; i < NPT; i++) begin re[i] = 0.0; im[i] = 0.0; wcnt[i] = 0; end
    re[0]  = 1000.0;
    nwr    = 0;
    mon_en = 1'b1;

    // Full run with impulse; stray start mid-run
    @(negedge clk);
    start = 1'b1;
    done_at = 0; last_wr = 0; ndone = 0;
    for (int c = 1; c <= 330; c++) begin
      @(negedge clk);
      if (c == 1)   start = 1'b0;
      if (c == 100) start = 1'b1;
      if (c == 101) start = 1'b0;
      if (c == 1) begin
        chk("c1_addr_a", ram_addr_a, 0);
        chk("c1_addr_b", ram_addr_b, 1);
      end
      if (c == 2) chk("c2_valid", bf_in_valid, 1);
      if (c == 4) chk("c4_wr", {ram_wr_a, ram_wr_b}, 2'b11);
      if (c == 149) begin
        chk("s2k5_a",  ram_addr_a, 9);
        chk("s2k5_b",  ram_addr_b, 13);
        chk("s2k5_tw", twiddle_idx, 4);
        chk("s2k5_st", stage, 2);
      end
      if (c == 317) begin
        chk("s4k15_a",  ram_addr_a, 15);
        chk("s4k15_b",  ram_addr_b, 31);
        chk("s4k15_tw", twiddle_idx, 15);
      end
      if (done) begin ndone++; done_at = c; end
      if (ram_wr_a) last_wr = c;
      if (c == 322) chk("c322_busy", busy, 0);
    end
    chk("done_cycle", done_at, TOTAL + 1);
    chk("last_write", last_wr, TOTAL);
    chk("done_count", ndone, 1);
    chk("write_cycles", nwr, LOG2N * HALF);
    for (int i = 0; i < NPT; i++) begin
      chk("addr_writes", wcnt[i], LOG2N);
      chk("fft_re", $rtoi(re[i] + 0.5), 1000);
      chk("fft_im", $rtoi(im[i] * 1000.0 + 0.5), 0);
    end

    // Asynchronous reset mid-run, then a clean restart
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",  busy, 0);
    chk("arst_wr",    {ram_wr_a, ram_wr_b}, 0);
    chk("arst_valid", bf_in_valid, 0);
    chk("arst_addr",  {ram_addr_a, ram_addr_b}, 0);
    chk("arst_twid",  twiddle_idx, 0);
    chk("arst_stage", stage, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_a",    ram_addr_a, 0);
    chk("restart_b",    ram_addr_b, 1);
    chk("restart_st",   stage, 0);
    wait_done(TOTAL + 10);

    // Random start traffic with occasional asynchronous resets
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 799) == 0) begin
        #2 rst_n = 1'b0;
        #1 chk("rnd_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    // start held high: back-to-back runs with a single idle cycle between them
    start = 1'b1;
    repeat (700) @(negedge clk);
    start = 1'b0;
    wait_done(TOTAL + 10);
    repeat (3) @(negedge clk);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
